// File: rtl/clksw_sequencer_if.sv
// clksw_sequencer_if: CPU-side config/handshake and clock-switch control/feedback bundle; master = CPU side + switch, slave = sequencer
interface clksw_sequencer_if;
  logic turbo_en;
  logic ls_req;
  logic div_sel_cfg;
  logic bypass_cfg;
  logic hsclk_selected;
  logic lsclk_selected;
  logic err_clr;
  logic hsclk_sel;
  logic cpuclk_div_sel;
  logic delay_bypass;
  logic ls_ready;
  logic in_hs;
  logic timeout_err;
  logic [15:0] hs_entries;
  modport master (
    output turbo_en, ls_req, div_sel_cfg, bypass_cfg, hsclk_selected, lsclk_selected, err_clr,
    input hsclk_sel, cpuclk_div_sel, delay_bypass, ls_ready, in_hs, timeout_err, hs_entries
  );
  modport slave (
    input turbo_en, ls_req, div_sel_cfg, bypass_cfg, hsclk_selected, lsclk_selected, err_clr,
    output hsclk_sel, cpuclk_div_sel, delay_bypass, ls_ready, in_hs, timeout_err, hs_entries
  );
endinterface

// File: rtl/clksw_sequencer.sv
// clksw_sequencer: HS/LS clock-switch sequencer; hsclk_in/rst plain ports, bus carries config in, switch feedback in, switch controls and host handshake out
module clksw_sequencer #(
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic hsclk_in,
  input logic rst,
  clksw_sequencer_if.slave bus
);
  typedef enum logic [2:0] {LS_RUN, TO_HS, HS_RUN, TO_LS, HOLD} state_t;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HLD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [SYNC_STAGES-1:0] hs_sync, ls_sync;
  logic hs_ok, ls_ok, want_ls, set_err;
  assign hs_ok = hs_sync[SYNC_STAGES-1] & ~ls_sync[SYNC_STAGES-1];
  assign ls_ok = ls_sync[SYNC_STAGES-1] & ~hs_sync[SYNC_STAGES-1];
  assign want_ls = bus.ls_req | ~bus.turbo_en;
  assign bus.ls_ready = (state == LS_RUN || state == HOLD) & ls_ok;
  // completion outranks timeout; a TO_HS abort already leaves without flagging
  assign set_err = cnt == TMO && ((state == TO_HS && !hs_ok && !want_ls) || (state == TO_LS && !ls_ok));
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      hs_sync <= '0;
      ls_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], bus.hsclk_selected};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], bus.lsclk_selected};
    end
  end
  always_ff @(posedge hsclk_in or posedge rst) begin
    if (rst) begin
      state <= LS_RUN;
      cnt <= '0;
      bus.hsclk_sel <= 1'b0;
      bus.cpuclk_div_sel <= 1'b0;
      bus.delay_bypass <= 1'b0;
      bus.in_hs <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.hs_entries <= '0;
    end else begin
      bus.timeout_err <= set_err | (bus.timeout_err & ~bus.err_clr);
      case (state)
        LS_RUN: begin
          // divider/bypass only move while the slow clock is confirmed
          if (ls_ok) begin
            bus.cpuclk_div_sel <= bus.div_sel_cfg;
            bus.delay_bypass <= bus.bypass_cfg;
          end
          if (!want_ls) begin
            state <= TO_HS;
            cnt <= '0;
            bus.hsclk_sel <= 1'b1;
          end
        end
        TO_HS: begin
          cnt <= cnt + ONE;
          if (hs_ok) begin
            state <= HS_RUN;
            bus.in_hs <= 1'b1;
            bus.hs_entries <= bus.hs_entries + 16'd1;
          end else if (want_ls || cnt == TMO) begin
            state <= TO_LS;
            cnt <= '0;
            bus.hsclk_sel <= 1'b0;
          end
        end
        HS_RUN: begin
          if (want_ls) begin
            state <= TO_LS;
            cnt <= '0;
            bus.hsclk_sel <= 1'b0;
            bus.in_hs <= 1'b0;
          end
        end
        TO_LS: begin
          if (ls_ok) begin
            state <= (HOLDOFF_CYCLES == 0) ? LS_RUN : HOLD;
            cnt <= HLD;
          end else if (cnt != TMO) begin
            cnt <= cnt + ONE;
          end
        end
        HOLD: begin
          if (cnt == ONE) state <= LS_RUN;
          else cnt <= cnt - ONE;
        end
        default: state <= LS_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_clksw_sequencer.sv
// tb_clksw_sequencer: table, directed and randomized checks of clksw_sequencer against a switch model and reference model
module tb_clksw_sequencer;
  localparam int SYNC = 2;
  localparam int TMO = 255;
  localparam int HLD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  clksw_sequencer_if bus();
  clksw_sequencer dut (.hsclk_in(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  // clock switch model: break-before-make, feedback settles some cycles after a select change
  bit sw_on = 1'b1;
  bit sw_rand = 1'b0;
  int sw_delay = 10;
  int sw_cnt = 0;
  logic tgt = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      tgt = 1'b0;
      sw_cnt = 0;
      bus.hsclk_selected = 1'b0;
      bus.lsclk_selected = 1'b1;
    end else if (!sw_on) begin
      bus.hsclk_selected = 1'b0;
      bus.lsclk_selected = 1'b0;
    end else if (bus.hsclk_sel !== tgt) begin
      tgt = bus.hsclk_sel;
      sw_cnt = sw_rand ? int'($urandom_range(1, 8)) : sw_delay;
      bus.hsclk_selected = 1'b0;
      bus.lsclk_selected = 1'b0;
    end else if (sw_cnt > 0) begin
      sw_cnt--;
      if (sw_cnt == 0) begin
        bus.hsclk_selected = tgt;
        bus.lsclk_selected = !tgt;
      end
    end
  end
  // reference model: modes named by intent, an age counter for time spent switching, a countdown for hysteresis
  string mode = "ls";
  int age, left;
  logic m_div, m_byp, m_err;
  logic [15:0] m_ent;
  logic ms_hs [SYNC];
  logic ms_ls [SYNC];
  always @(posedge clk or posedge rst) begin
    bit hs_ok, ls_ok, leave, tmo;
    if (rst) begin
      mode = "ls";
      age = 0;
      left = 0;
      m_div = 1'b0;
      m_byp = 1'b0;
      m_err = 1'b0;
      m_ent = '0;
      for (int i = 0; i < SYNC; i++) begin
        ms_hs[i] = 1'b0;
        ms_ls[i] = 1'b1;
      end
    end else begin
      hs_ok = ms_hs[SYNC-1] && !ms_ls[SYNC-1];
      ls_ok = ms_ls[SYNC-1] && !ms_hs[SYNC-1];
      leave = bus.ls_req || !bus.turbo_en;
      tmo = 1'b0;
      if (mode == "ls") begin
        if (ls_ok) begin
          m_div = bus.div_sel_cfg;
          m_byp = bus.bypass_cfg;
        end
        if (!leave) begin
          mode = "to_hs";
          age = 0;
        end
      end else if (mode == "to_hs") begin
        if (hs_ok) begin
          mode = "hs";
          m_ent = m_ent + 16'd1;
        end else if (leave) begin
          mode = "to_ls";
          age = 0;
        end else if (age == TMO) begin
          tmo = 1'b1;
          mode = "to_ls";
          age = 0;
        end else age++;
      end else if (mode == "hs") begin
        if (leave) begin
          mode = "to_ls";
          age = 0;
        end
      end else if (mode == "to_ls") begin
        if (ls_ok) begin
          mode = (HLD == 0) ? "ls" : "hold";
          left = HLD;
        end else if (age == TMO) tmo = 1'b1;
        else age++;
      end else begin
        if (left == 1) mode = "ls";
        else left--;
      end
      m_err = tmo | (m_err & !bus.err_clr);
      for (int i = SYNC - 1; i > 0; i--) begin
        ms_hs[i] = ms_hs[i-1];
        ms_ls[i] = ms_ls[i-1];
      end
      ms_hs[0] = bus.hsclk_selected;
      ms_ls[0] = bus.lsclk_selected;
    end
  end
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.turbo_en = 1'b0;
    bus.ls_req = 1'b0;
    bus.div_sel_cfg = 1'b0;
    bus.bypass_cfg = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_sig(input string nm, input int which, input int lim);
    int n = 0;
    while ((which == 0 ? bus.in_hs : bus.ls_ready) !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    check(nm, 32'(n < lim), 32'(1));
  endtask
  typedef struct {
    bit turbo, req, div, byp;
    int n;
    bit e_sel, e_hs, e_rdy, e_div, e_byp;
    int e_ent;
  } vec_t;
  vec_t tbl [6];
  initial begin
    int n;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    do_reset();
    check("rst_hsclk_sel", 32'(bus.hsclk_sel), 32'(0));
    check("rst_div", 32'(bus.cpuclk_div_sel), 32'(0));
    check("rst_bypass", 32'(bus.delay_bypass), 32'(0));
    check("rst_ls_ready", 32'(bus.ls_ready), 32'(1));
    check("rst_in_hs", 32'(bus.in_hs), 32'(0));
    check("rst_timeout_err", 32'(bus.timeout_err), 32'(0));
    check("rst_hs_entries", 32'(bus.hs_entries), 32'(0));
    for (int i = 0; i < 6; i++) begin
      bus.turbo_en = tbl[i].turbo;
      bus.ls_req = tbl[i].req;
      bus.div_sel_cfg = tbl[i].div;
      bus.bypass_cfg = tbl[i].byp;
      repeat (tbl[i].n) tick();
      check($sformatf("tbl%0d_sel", i), 32'(bus.hsclk_sel), 32'(tbl[i].e_sel));
      check($sformatf("tbl%0d_in_hs", i), 32'(bus.in_hs), 32'(tbl[i].e_hs));
      check($sformatf("tbl%0d_ls_ready", i), 32'(bus.ls_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_div", i), 32'(bus.cpuclk_div_sel), 32'(tbl[i].e_div));
      check($sformatf("tbl%0d_bypass", i), 32'(bus.delay_bypass), 32'(tbl[i].e_byp));
      check($sformatf("tbl%0d_entries", i), 32'(bus.hs_entries), 32'(tbl[i].e_ent));
      check($sformatf("tbl%0d_err", i), 32'(bus.timeout_err), 32'(0));
    end
    // LS->HS latency, then HS->LS with hysteresis
    do_reset();
    bus.turbo_en = 1'b1;
    tick();
    check("sel_cycle1", 32'(bus.hsclk_sel), 32'(1));
    n = 1;
    while (bus.in_hs !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("in_hs_latency_12_15", 32'(n >= 12 && n <= 15), 32'(1));
    check("entries_after_hs", 32'(bus.hs_entries), 32'(1));
    bus.ls_req = 1'b1;
    tick();
    check("sel_drop_next_edge", 32'(bus.hsclk_sel), 32'(0));
    check("ready_not_early", 32'(bus.ls_ready), 32'(0));
    n = 0;
    while (bus.ls_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("ready_after_sync", 32'(n >= 12 && n < 60), 32'(1));
    bus.ls_req = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.hsclk_sel !== 1'b0) break;
      n++;
    end
    check("hold_cycles", 32'(n), 32'(HLD));
    // abort three cycles into TO_HS
    do_reset();
    bus.turbo_en = 1'b1;
    repeat (3) tick();
    bus.ls_req = 1'b1;
    tick();
    bus.ls_req = 1'b0;
    bus.turbo_en = 1'b0;
    check("abort_sel", 32'(bus.hsclk_sel), 32'(0));
    check("abort_in_hs", 32'(bus.in_hs), 32'(0));
    repeat (40) tick();
    check("abort_entries", 32'(bus.hs_entries), 32'(0));
    check("abort_err", 32'(bus.timeout_err), 32'(0));
    check("abort_back_ls", 32'(bus.ls_ready), 32'(1));
    // dead switch: TO_HS timeout, err_clr, then saturated TO_LS timeout beating err_clr
    sw_on = 1'b0;
    do_reset();
    bus.turbo_en = 1'b1;
    tick();
    check("tmo_sel_on", 32'(bus.hsclk_sel), 32'(1));
    repeat (255) tick();
    check("tmo_not_yet", 32'(bus.timeout_err), 32'(0));
    tick();
    check("tmo_set_256", 32'(bus.timeout_err), 32'(1));
    check("tmo_sel_off", 32'(bus.hsclk_sel), 32'(0));
    check("tmo_in_hs", 32'(bus.in_hs), 32'(0));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo_err_clr", 32'(bus.timeout_err), 32'(0));
    repeat (254) tick();
    check("tmo_ls_not_yet", 32'(bus.timeout_err), 32'(0));
    tick();
    check("tmo_ls_set", 32'(bus.timeout_err), 32'(1));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo_set_beats_clr", 32'(bus.timeout_err), 32'(1));
    check("tmo_sel_stays_off", 32'(bus.hsclk_sel), 32'(0));
    sw_on = 1'b1;
    // async reset in TO_HS and in HOLD
    do_reset();
    bus.turbo_en = 1'b1;
    repeat (2) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_to_hs_sel", 32'(bus.hsclk_sel), 32'(0));
    check("arst_to_hs_in_hs", 32'(bus.in_hs), 32'(0));
    bus.turbo_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("arst_to_hs_ready", 32'(bus.ls_ready), 32'(1));
    bus.turbo_en = 1'b1;
    tick();
    check("arst_to_hs_ls_run", 32'(bus.hsclk_sel), 32'(1));
    wait_sig("reach_hs_bound", 0, 40);
    bus.ls_req = 1'b1;
    wait_sig("reach_hold_bound", 1, 60);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hold_sel", 32'(bus.hsclk_sel), 32'(0));
    check("arst_hold_in_hs", 32'(bus.in_hs), 32'(0));
    check("arst_hold_entries", 32'(bus.hs_entries), 32'(0));
    check("arst_hold_err", 32'(bus.timeout_err), 32'(0));
    bus.ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.turbo_en = 1'b1;
    tick();
    check("arst_hold_ls_run", 32'(bus.hsclk_sel), 32'(1));
    // randomized traffic against the reference model
    sw_rand = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      check($sformatf("rand_c%0d {sel,div,byp,rdy,hs,err,ent}", c),
            32'({bus.hsclk_sel, bus.cpuclk_div_sel, bus.delay_bypass, bus.ls_ready,
                 bus.in_hs, bus.timeout_err, bus.hs_entries}),
            32'({mode == "to_hs" || mode == "hs", m_div, m_byp,
                 (mode == "ls" || mode == "hold") && ms_ls[SYNC-1] && !ms_hs[SYNC-1],
                 mode == "hs", m_err, m_ent}));
      bus.turbo_en = $urandom_range(0, 9) != 0;
      bus.ls_req = $urandom_range(0, 4) == 0;
      bus.div_sel_cfg = 1'($urandom);
      bus.bypass_cfg = 1'($urandom);
      bus.err_clr = $urandom_range(0, 19) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clksw_sequencer.md
# clksw_sequencer

Sequencer for the HS/LS CPU clock switch. Runs on the raw high-speed oscillator and decides when to request the fast clock. It drives the switch's select, divider and delay-bypass controls, and gives the CPU-side logic a handshake that confirms the slow (host) clock is in effect before a host-bus access proceeds. It adds LS hysteresis, a feedback timeout, and glitch-safe updates of divider/bypass configuration.

## Interface
- `HOLDOFF_CYCLES`, 16: hsclk_in cycles to remain in LS after an HS→LS switch completes; 0 = no hold.
- `TIMEOUT_CYCLES`, 255: cycles allowed for switch feedback before error; must be < 2^CNT_W.
- `CNT_W`, 8: width of the shared holdoff/timeout counter.
- `SYNC_STAGES`, 2: synchronizer depth on feedback inputs; minimum 2.
- `hsclk_in` in 1: sole clock, raw high-speed oscillator; all flops on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `turbo_en` in 1: config; 1 permits HS operation.
- `ls_req` in 1: level, synchronous; current/next CPU cycle needs host clock.
- `div_sel_cfg` in 1: requested cpuclk_div_sel (1 = /4, 0 = /2).
- `bypass_cfg` in 1: requested delay_bypass.
- `hsclk_selected` in 1: async feedback from clock switch.
- `lsclk_selected` in 1: async feedback from clock switch.
- `err_clr` in 1: single-cycle pulse; clears timeout_err.
- `hsclk_sel` out 1: registered request to the clock switch.
- `cpuclk_div_sel` out 1: registered divider select.
- `delay_bypass` out 1: registered delay bypass.
- `ls_ready` out 1: LS confirmed; host access may proceed.
- `in_hs` out 1: HS confirmed (state HS_RUN).
- `timeout_err` out 1: sticky feedback-timeout flag.
- `hs_entries` out 16: count of completed LS→HS switches; wraps.

## Operation
- Feedback inputs pass through SYNC_STAGES flops: hs_s resets to 0, ls_s resets to 1.
- States: LS_RUN, TO_HS, HS_RUN, TO_LS, HOLD. Reset state is LS_RUN.
- Reset values: all outputs 0 except ls_ready, which takes its combinational value (1 after sync reset values); counter 0.
- LS_RUN:
  - hsclk_sel=0.
  - While ls_s=1 and hs_s=0, latch div_sel_cfg→cpuclk_div_sel and bypass_cfg→delay_bypass each cycle. These outputs never change in any other state.
  - If turbo_en=1 and ls_req=0, go to TO_HS and clear the counter.
- TO_HS:
  - hsclk_sel=1, counter increments.
  - hs_s=1 and ls_s=0: go to HS_RUN, hs_entries+1.
  - Else ls_req=1 or turbo_en=0 (abort): go to TO_LS, counter cleared.
  - Else counter==TIMEOUT_CYCLES: set timeout_err, go to TO_LS, counter cleared.
- HS_RUN: hsclk_sel=1. If ls_req=1 or turbo_en=0, go to TO_LS and clear the counter.
- TO_LS:
  - hsclk_sel=0.
  - ls_s=1 and hs_s=0: go to HOLD and load HOLDOFF_CYCLES; if HOLDOFF_CYCLES=0, go to LS_RUN.
  - counter==TIMEOUT_CYCLES: set timeout_err and stay in TO_LS. The counter saturates and hsclk_sel is never reasserted.
- HOLD: hsclk_sel=0, counter decrements. At 1, go to LS_RUN. ls_req and turbo_en are ignored.
- ls_ready = (state ∈ {LS_RUN, HOLD}) & ls_s & !hs_s.
- in_hs = (state==HS_RUN).
- Simultaneous events:
  - err_clr together with a new timeout: the set wins.
  - Abort in TO_HS wins over completion only if the completion condition is false that cycle.
  - Completion has priority over timeout.
- rst mid-switch returns to LS_RUN immediately with hsclk_sel=0. The clock switch's own reset is relied on for glitch-free recovery.

## Timing
- All state and outputs update on the hsclk_in posedge. Inputs are sampled on the same edge.
- ls_req rising, sampled at edge N in HS_RUN: hsclk_sel=0 after edge N.
  - Switch feedback arrives, then ls_s is seen SYNC_STAGES edges later.
  - ls_ready rises the cycle after the HOLD entry edge.
- LS_RUN→HS request: hsclk_sel=1 one edge after the sample. in_hs=1 the edge after hs_s and !ls_s are both seen.
- Timeout: timeout_err is set on the edge where the counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 cycles after entering TO_HS/TO_LS.
- HOLD lasts exactly HOLDOFF_CYCLES cycles.

## Test plan
- Reset, then turbo_en=1, ls_req=0, with a switch model responding in 10 cycles:
  - hsclk_sel=1 at cycle 1.
  - in_hs=1 at ~cycle 13.
  - hs_entries=1.
- In HS_RUN, assert ls_req:
  - hsclk_sel=0 on the next edge.
  - ls_ready=1 only after lsclk_selected is synced.
  - hsclk_sel stays 0 for 16 HOLD cycles even after ls_req drops.
- Change div_sel_cfg and bypass_cfg while in HS_RUN:
  - outputs are unchanged.
  - outputs update within 1 cycle of reaching LS_RUN with ls_s=1.
- Switch model never responds with TIMEOUT_CYCLES=255:
  - timeout_err=1 on the 256th cycle, state TO_LS, hsclk_sel=0.
  - err_clr clears the flag only when no new timeout occurs that cycle.
- Pulse ls_req 3 cycles into TO_HS (abort):
  - go to TO_LS.
  - hs_entries does not increment.
  - no timeout_err.
- Assert rst in TO_HS and in HOLD:
  - hsclk_sel=0 and in_hs=0 asynchronously.
  - state LS_RUN after release.
  - hs_entries and timeout_err are 0.
